// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte requesters. In IDLE, with
// the transmitter not busy, a round-robin scan starting after the last
// served requester picks a winner. The winner's byte is captured into tx_din,
// and tx_trigger/req_ready[w] pulse for one cycle. The grant is then held in
// WAIT_DONE until tx_done arrives, at which point sent_done[w] pulses.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): a completion watchdog.
// It abandons the grant and pulses timeout_err once TIMEOUT_CYCLES cycles
// have passed in WAIT_DONE without tx_done. Without the macro the arbiter
// waits indefinitely, and timeout_err is tied low.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid[N]      requester i has a byte pending
//   req_data[8N]      byte of requester i at [8i+7:8i]
//   req_ready[N]      one-cycle pulse: byte of requester i was taken
//   sent_done[N]      one-cycle pulse: byte of requester i finished sending
//   tx_trigger        one-cycle launch pulse to the transmitter
//   tx_din[8]         byte to transmit, held until the next grant
//   tx_busy, tx_done  transmitter status inputs
//   grant_id          index of the current or last granted requester
//   active            high while not IDLE
//   timeout_err       one-cycle watchdog expiry pulse
// All outputs are driven directly from flops.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         sent_done,
    output logic                       tx_trigger,
    output logic [7:0]                 tx_din,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [7:0]           tx_din_q, tx_din_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   sent_done_q, sent_done_d;
    logic                 tx_trigger_q, tx_trigger_d;

    // Round-robin winner: first set req_valid bit scanning upward from last+1.
    logic                 found;
    logic [IDW-1:0]       win;
    int                   idx;

    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_q) + off) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        tx_din_d     = tx_din_q;
        req_ready_d  = '0;
        sent_done_d  = '0;
        tx_trigger_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // tx_done arriving here is deliberately ignored.
                if (!tx_busy && found) begin
                    grant_id_d   = win;
                    tx_din_d     = req_data[8*win +: 8];
                    req_ready_d  = NUM_REQ'(1) << win;
                    tx_trigger_d = 1'b1;
                    state_d      = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            WAIT_DONE: begin
                // tx_done takes priority over a watchdog expiry in the same cycle.
                if (tx_done) begin
                    sent_done_d = NUM_REQ'(1) << grant_id_q;
                    last_d      = grant_id_q;
                    state_d     = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc[15:0];
                    if (cnt_inc == 17'(TIMEOUT_CYCLES)) begin
                        timeout_err_d = 1'b1;
                        last_d        = grant_id_q;
                        state_d       = IDLE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_din_q     <= '0;
            req_ready_q  <= '0;
            sent_done_q  <= '0;
            tx_trigger_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            tx_din_q     <= tx_din_d;
            req_ready_q  <= req_ready_d;
            sent_done_q  <= sent_done_d;
            tx_trigger_q <= tx_trigger_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_err        = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign sent_done  = sent_done_q;
    assign tx_trigger = tx_trigger_q;
    assign tx_din     = tx_din_q;
    assign grant_id   = grant_id_q;
    assign active     = (state_q == WAIT_DONE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=100).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, so each sample shows the flops loaded on that edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  sent_done;
    logic        tx_trigger;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .sent_done   (sent_done),
        .tx_trigger  (tx_trigger),
        .tx_din      (tx_din),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'h0);
        check({tag, "_sent_done"},   32'(sent_done),   32'h0);
        check({tag, "_tx_trigger"},  32'(tx_trigger),  32'h0);
        check({tag, "_tx_din"},      32'(tx_din),      32'h0);
        check({tag, "_grant_id"},    32'(grant_id),    32'h0);
        check({tag, "_active"},      32'(active),      32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    logic [1:0] exp_g [5];
    logic [7:0] exp_d [5];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        tick();
        tick();
        check_all_zero("reset");

        // Single request from requester 2
        rst       = 1'b0;
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        tick();
        check("single_trig",  32'(tx_trigger), 32'h1);
        check("single_ready", 32'(req_ready),  32'h4);
        check("single_din",   32'(tx_din),     32'hA5);
        check("single_gid",   32'(grant_id),   32'h2);
        check("single_act",   32'(active),     32'h1);
        req_valid = 4'b0000;
        tick();
        check("single_trig_off",  32'(tx_trigger), 32'h0);
        check("single_ready_off", 32'(req_ready),  32'h0);
        check("single_din_hold",  32'(tx_din),     32'hA5);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single_sent", 32'(sent_done), 32'h4);
        check("single_idle", 32'(active),    32'h0);
        tick();
        check("single_sent_off", 32'(sent_done), 32'h0);

        // Fairness from reset, with 2-cycle back-to-back spacing after tx_done
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fair_trig", 32'(tx_trigger), 32'h1);
            check("fair_gid",  32'(grant_id),   32'(exp_g[i]));
            check("fair_din",  32'(tx_din),     32'(exp_d[i]));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("fair_sent",     32'(sent_done),  32'(4'b0001 << exp_g[i]));
            check("fair_gap_trig", 32'(tx_trigger), 32'h0);
        end
        req_valid = 4'b0000;
        tick();
        check("fair_idle", 32'(active), 32'h0);

        // Busy gate: requester 1 waits while tx_busy is high
        tx_busy   = 1'b1;
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("busy_no_trig", 32'(tx_trigger), 32'h0);
            check("busy_no_act",  32'(active),     32'h0);
        end
        tx_busy = 1'b0;
        tick();
        check("busy_trig",  32'(tx_trigger), 32'h1);
        check("busy_gid",   32'(grant_id),   32'h1);
        check("busy_din",   32'(tx_din),     32'h3C);
        check("busy_ready", 32'(req_ready),  32'h2);
        req_valid = 4'b0000;
        tx_done   = 1'b1;
        tick();
        tx_done = 1'b0;
        check("busy_sent", 32'(sent_done), 32'h2);
        // tx_done in IDLE must be ignored
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("idle_done_ignored", 32'(sent_done), 32'h0);

        // Reset mid-frame: grant requester 3, then reset inside WAIT_DONE
        req_valid = 4'b1000;
        req_data  = 32'h7700_0000;
        tick();
        check("rst_pre_gid", 32'(grant_id), 32'h3);
        req_valid = 4'b0000;
        tick();
        check("rst_pre_act", 32'(active), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_mid");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("rst_no_sent", 32'(sent_done), 32'h0);
        // With priority pointer back at 3, requester 0 beats requester 3
        req_valid = 4'b1001;
        req_data  = 32'h6600_0055;
        tick();
        req_valid = 4'b0000;
        check("rst_next_gid",   32'(grant_id),  32'h0);
        check("rst_next_ready", 32'(req_ready), 32'h1);
        check("rst_next_din",   32'(tx_din),    32'h55);

        // Watchdog: tx_done withheld after the grant above
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 99; i++) begin
            tick();
            check("to_wait_err", 32'(timeout_err), 32'h0);
            check("to_wait_act", 32'(active),      32'h1);
        end
        tick();
        check("to_err",     32'(timeout_err), 32'h1);
        check("to_no_sent", 32'(sent_done),   32'h0);
        check("to_idle",    32'(active),      32'h0);
        tick();
        check("to_err_off", 32'(timeout_err), 32'h0);
`else
        for (int i = 0; i < 150; i++) begin
            tick();
            check("nto_err", 32'(timeout_err), 32'h0);
            check("nto_act", 32'(active),      32'h1);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("nto_sent", 32'(sent_done), 32'h1);
        check("nto_idle", 32'(active),    32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
